// File: rtl/router_pkg.sv
// Shared types for the router egress packet collector: header layout, FSM states,
// FIFO entry format and statistics counter width.
package router_pkg;

  localparam int STAT_W = 16;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] dst;
  } pkt_hdr_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    TAIL,
    DISCARD
  } coll_state_e;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_commit_fifo.sv
// Byte FIFO with a speculative write pointer: packets are written speculatively and
// become visible to the reader only on commit; rewind throws away the uncommitted part.
module router_commit_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  fifo_entry_t wr_entry,
  input  logic        commit,
  input  logic        rewind,
  input  logic        pop,
  output fifo_entry_t rd_entry,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] rptr_reg;
  logic [AW:0] wptr_commit_reg;
  logic [AW:0] wptr_spec_reg;
  logic [AW:0] occ_spec;
  fifo_entry_t mem [DEPTH];

  // Extra pointer MSB lets a full FIFO be told apart from an empty one.
  assign occ_spec = wptr_spec_reg - rptr_reg;
  assign full     = (occ_spec == (AW+1)'(DEPTH));
  assign empty    = (rptr_reg == wptr_commit_reg);
  assign rd_entry = mem[rptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_spec_reg[AW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_reg        <= '0;
      wptr_commit_reg <= '0;
      wptr_spec_reg   <= '0;
    end else begin
      if (pop && !empty) begin
        rptr_reg <= rptr_reg + (AW+1)'(1);
      end
      if (rewind) begin
        wptr_spec_reg <= wptr_commit_reg;
      end else if (wr_en) begin
        wptr_spec_reg <= wptr_spec_reg + (AW+1)'(1);
      end
      if (commit) begin
        wptr_commit_reg <= wptr_spec_reg;
      end
    end
  end

endmodule

// File: rtl/router_pkt_collector.sv
// Egress packet collector: checks framing, commits good packets into a byte FIFO and
// streams them out with sop/eop. Statistics counters exist only with ROUTER_COLLECTOR_STATS_EN.
module router_pkt_collector
  import router_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int MAX_PAYLOAD = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        da,
  input  logic              da_valid,
  output logic [7:0]        out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr_stats,
  output logic [STAT_W-1:0] ok_cnt,
  output logic [STAT_W-1:0] err_cnt,
  output logic [STAT_W-1:0] drop_cnt
);

  localparam int         RW    = $clog2(MAX_PAYLOAD + 1);
  localparam logic [7:0] MAX_N = 8'(MAX_PAYLOAD);

  coll_state_e   state_reg, state_next;
  logic [RW-1:0] remaining_reg, remaining_next;
  logic          want_wr, wr_en, commit, rewind;
  logic          ok_inc, err_inc, drop_inc;
  logic          full, empty;
  fifo_entry_t   wr_entry, rd_entry;

  router_commit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_entry(wr_entry),
    .commit  (commit),
    .rewind  (rewind),
    .pop     (out_ready),
    .rd_entry(rd_entry),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = !empty;
  assign out_data  = out_valid ? rd_entry.data : 8'h00;
  assign out_sop   = out_valid & rd_entry.sop;
  assign out_eop   = out_valid & rd_entry.eop;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    want_wr        = 1'b0;
    wr_en          = 1'b0;
    wr_entry       = '0;
    commit         = 1'b0;
    rewind         = 1'b0;
    ok_inc         = 1'b0;
    err_inc        = 1'b0;
    drop_inc       = 1'b0;
    wr_entry.data  = da;
    case (state_reg)
      IDLE: begin
        if (da_valid) begin
          want_wr      = 1'b1;
          wr_entry.sop = 1'b1;
          state_next   = LEN;
        end
      end
      LEN: begin
        if (!da_valid) begin
          err_inc    = 1'b1;
          rewind     = 1'b1;
          state_next = IDLE;
        end else if (da == 8'h00 || da > MAX_N) begin
          err_inc    = 1'b1;
          rewind     = 1'b1;
          state_next = DISCARD;
        end else begin
          want_wr        = 1'b1;
          remaining_next = RW'(da);
          state_next     = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!da_valid) begin
          err_inc    = 1'b1;
          rewind     = 1'b1;
          state_next = IDLE;
        end else begin
          want_wr        = 1'b1;
          wr_entry.eop   = (remaining_reg == RW'(1));
          remaining_next = remaining_reg - RW'(1);
          if (remaining_reg == RW'(1)) begin
            state_next = TAIL;
          end
        end
      end
      TAIL: begin
        if (!da_valid) begin
          commit     = 1'b1;
          ok_inc     = 1'b1;
          state_next = IDLE;
        end else begin
          err_inc    = 1'b1;
          rewind     = 1'b1;
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (!da_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A write into a full FIFO drops the whole packet instead of flagging an error.
    if (want_wr && full) begin
      drop_inc   = 1'b1;
      rewind     = 1'b1;
      state_next = DISCARD;
    end else begin
      wr_en = want_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
    end
  end

`ifdef ROUTER_COLLECTOR_STATS_EN
  logic [2:0]          cnt_inc;
  logic [3*STAT_W-1:0] cnt_all;

  assign cnt_inc = {drop_inc, err_inc, ok_inc};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [STAT_W-1:0] cnt_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (clr_stats) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && cnt_reg != '1) begin
        cnt_reg <= cnt_reg + STAT_W'(1);
      end
    end
    assign cnt_all[gi*STAT_W +: STAT_W] = cnt_reg;
  end

  assign ok_cnt   = cnt_all[0*STAT_W +: STAT_W];
  assign err_cnt  = cnt_all[1*STAT_W +: STAT_W];
  assign drop_cnt = cnt_all[2*STAT_W +: STAT_W];
`else
  logic unused_stats;
  assign unused_stats = ^{clr_stats, ok_inc, err_inc, drop_inc};
  assign ok_cnt       = '0;
  assign err_cnt      = '0;
  assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_router_pkt_collector.sv
// Directed testbench for router_pkt_collector: framing errors, full drop, wrap-around,
// reset and statistics clear.
module tb_router_pkt_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  da;
  logic        da_valid;
  logic [7:0]  out_data;
  logic        out_sop, out_eop, out_valid;
  logic        out_ready;
  logic        clr_stats;
  logic [15:0] ok_cnt, err_cnt, drop_cnt;

  typedef logic [7:0] bq_t[$];

  int        compared   = 0;
  int        mismatched = 0;
  int        ok_exp     = 0;
  int        err_exp    = 0;
  int        drop_exp   = 0;
  logic [9:0] rx[$];
  logic [9:0] expq[$];

`ifdef ROUTER_COLLECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  router_pkt_collector #(
    .DEPTH(64),
    .MAX_PAYLOAD(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .da       (da),
    .da_valid (da_valid),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .clr_stats(clr_stats),
    .ok_cnt   (ok_cnt),
    .err_cnt  (err_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Record every byte the consumer accepts; the pop itself happens on the next rising edge.
  always @(negedge clk) begin
    #1;
    if (!reset && out_valid && out_ready) rx.push_back({out_sop, out_eop, out_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] cexp(input int n);
    return STATS ? 16'(n) : 16'h0000;
  endfunction

  task automatic send_bytes(input bq_t b);
    foreach (b[i]) begin
      @(negedge clk);
      da       = b[i];
      da_valid = 1'b1;
    end
  endtask

  task automatic end_pkt();
    @(negedge clk);
    da_valid = 1'b0;
    da       = 8'h00;
  endtask

  task automatic send_pkt(input bq_t b);
    send_bytes(b);
    end_pkt();
  endtask

  task automatic mk_pkt(input logic [7:0] hdr, input int n, input logic [7:0] seed, output bq_t b);
    b = {};
    b.push_back(hdr);
    b.push_back(8'(n));
    for (int i = 0; i < n; i++) b.push_back(seed + 8'(i));
  endtask

  task automatic add_exp(input bq_t b);
    foreach (b[i]) expq.push_back({(i == 0), (i == b.size() - 1), b[i]});
  endtask

  task automatic wait_rx(input int n);
    for (int c = 0; c < 2000 && rx.size() < n; c++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; da = 8'h00; da_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    compared += 7;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", out_valid); end
    if (out_sop !== 1'b0) begin mismatched++; $display("FAIL rst_sop got %b want 0", out_sop); end
    if (out_eop !== 1'b0) begin mismatched++; $display("FAIL rst_eop got %b want 0", out_eop); end
    if (out_data !== 8'h00) begin mismatched++; $display("FAIL rst_data got %h want 00", out_data); end
    if (ok_cnt !== 16'h0) begin mismatched++; $display("FAIL rst_ok got %0d want 0", ok_cnt); end
    if (err_cnt !== 16'h0) begin mismatched++; $display("FAIL rst_err got %0d want 0", err_cnt); end
    if (drop_cnt !== 16'h0) begin mismatched++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    bq_t b;
    b = {8'h12, 8'h03, 8'hA1, 8'hA2, 8'hA3};
    add_exp(b);
    send_bytes(b);
    @(negedge clk);
    da_valid = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL lat_early got %b want 0", out_valid); end
    @(negedge clk);
    #1;
    compared += 3;
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL lat_valid got %b want 1", out_valid); end
    if (out_sop !== 1'b1) begin mismatched++; $display("FAIL lat_sop got %b want 1", out_sop); end
    if (out_data !== 8'h12) begin mismatched++; $display("FAIL lat_data got %h want 12", out_data); end
    @(negedge clk);
    out_ready = 1'b1;
    wait_rx(5);
    ok_exp++;
    compared++;
    if (rx.size() !== expq.size()) begin mismatched++; $display("FAIL single_len got %0d want %0d", rx.size(), expq.size()); end
    foreach (expq[i]) if (i < rx.size()) begin
      compared++;
      if (rx[i] !== expq[i]) begin mismatched++; $display("FAIL single_byte%0d got %h want %h", i, rx[i], expq[i]); end
    end
    compared++;
    if (ok_cnt !== cexp(ok_exp)) begin mismatched++; $display("FAIL single_ok got %0d want %0d", ok_cnt, cexp(ok_exp)); end
    rx = {}; expq = {};
    $display("test_single done");
  endtask

  task automatic test_truncated();
    bq_t b;
    b = {8'h34, 8'h04, 8'hB1, 8'hB2};
    send_pkt(b);
    repeat (5) @(negedge clk);
    err_exp++;
    #1;
    compared += 3;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL trunc_valid got %b want 0", out_valid); end
    if (rx.size() !== 0) begin mismatched++; $display("FAIL trunc_rx got %0d want 0", rx.size()); end
    if (err_cnt !== cexp(err_exp)) begin mismatched++; $display("FAIL trunc_err got %0d want %0d", err_cnt, cexp(err_exp)); end
    b = {8'h21, 8'h01, 8'h5A};
    add_exp(b);
    send_pkt(b);
    wait_rx(3);
    ok_exp++;
    compared++;
    if (rx.size() !== expq.size()) begin mismatched++; $display("FAIL trunc_next_len got %0d want %0d", rx.size(), expq.size()); end
    foreach (expq[i]) if (i < rx.size()) begin
      compared++;
      if (rx[i] !== expq[i]) begin mismatched++; $display("FAIL trunc_next_byte%0d got %h want %h", i, rx[i], expq[i]); end
    end
    rx = {}; expq = {};
    $display("test_truncated done");
  endtask

  task automatic test_bad_length();
    bq_t b;
    b = {8'h40, 8'h02, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_pkt(b);
    repeat (2) @(negedge clk);
    err_exp++;
    #1;
    compared++;
    if (err_cnt !== cexp(err_exp)) begin mismatched++; $display("FAIL overrun_err got %0d want %0d", err_cnt, cexp(err_exp)); end
    b = {8'h41, 8'h00, 8'hD1};
    send_pkt(b);
    repeat (2) @(negedge clk);
    err_exp++;
    #1;
    compared++;
    if (err_cnt !== cexp(err_exp)) begin mismatched++; $display("FAIL len0_err got %0d want %0d", err_cnt, cexp(err_exp)); end
    b = {8'h42, 8'h21, 8'hE1, 8'hE2};
    send_pkt(b);
    repeat (4) @(negedge clk);
    err_exp++;
    #1;
    compared += 3;
    if (err_cnt !== cexp(err_exp)) begin mismatched++; $display("FAIL len33_err got %0d want %0d", err_cnt, cexp(err_exp)); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL badlen_valid got %b want 0", out_valid); end
    if (rx.size() !== 0) begin mismatched++; $display("FAIL badlen_rx got %0d want 0", rx.size()); end
    rx = {};
    $display("test_bad_length done");
  endtask

  task automatic test_full();
    bq_t b;
    @(negedge clk);
    out_ready = 1'b0;
    for (int p = 0; p < 7; p++) begin
      mk_pkt(8'h50 + 8'(p), 8, 8'(p * 16), b);
      send_pkt(b);
      if (p < 6) add_exp(b);
    end
    repeat (3) @(negedge clk);
    ok_exp += 6;
    drop_exp++;
    #1;
    compared += 4;
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL full_valid got %b want 1", out_valid); end
    if (drop_cnt !== cexp(drop_exp)) begin mismatched++; $display("FAIL full_drop got %0d want %0d", drop_cnt, cexp(drop_exp)); end
    if (ok_cnt !== cexp(ok_exp)) begin mismatched++; $display("FAIL full_ok got %0d want %0d", ok_cnt, cexp(ok_exp)); end
    if (err_cnt !== cexp(err_exp)) begin mismatched++; $display("FAIL full_err got %0d want %0d", err_cnt, cexp(err_exp)); end
    @(negedge clk);
    out_ready = 1'b1;
    wait_rx(60);
    compared++;
    if (rx.size() !== expq.size()) begin mismatched++; $display("FAIL full_len got %0d want %0d", rx.size(), expq.size()); end
    foreach (expq[i]) if (i < rx.size()) begin
      compared++;
      if (rx[i] !== expq[i]) begin mismatched++; $display("FAIL full_byte%0d got %h want %h", i, rx[i], expq[i]); end
    end
    rx = {}; expq = {};
    $display("test_full done");
  endtask

  task automatic test_wrap();
    bq_t b;
    for (int p = 0; p < 20; p++) begin
      mk_pkt(8'(p), 32, 8'(p * 7), b);
      send_pkt(b);
      add_exp(b);
    end
    wait_rx(680);
    ok_exp += 20;
    compared += 2;
    if (rx.size() !== expq.size()) begin mismatched++; $display("FAIL wrap_len got %0d want %0d", rx.size(), expq.size()); end
    if (ok_cnt !== cexp(ok_exp)) begin mismatched++; $display("FAIL wrap_ok got %0d want %0d", ok_cnt, cexp(ok_exp)); end
    foreach (expq[i]) if (i < rx.size()) begin
      compared++;
      if (rx[i] !== expq[i]) begin mismatched++; $display("FAIL wrap_byte%0d got %h want %h", i, rx[i], expq[i]); end
    end
    rx = {}; expq = {};
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    bq_t b;
    @(negedge clk);
    out_ready = 1'b0;
    b = {8'h60, 8'h01, 8'h77};
    send_pkt(b);
    b = {8'h61, 8'h05, 8'hF1, 8'hF2};
    send_bytes(b);
    @(negedge clk);
    reset = 1'b1;
    da    = 8'hF3;
    #1;
    compared += 7;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_valid got %b want 0", out_valid); end
    if (out_sop !== 1'b0) begin mismatched++; $display("FAIL mid_sop got %b want 0", out_sop); end
    if (out_eop !== 1'b0) begin mismatched++; $display("FAIL mid_eop got %b want 0", out_eop); end
    if (out_data !== 8'h00) begin mismatched++; $display("FAIL mid_data got %h want 00", out_data); end
    if (ok_cnt !== 16'h0) begin mismatched++; $display("FAIL mid_ok got %0d want 0", ok_cnt); end
    if (err_cnt !== 16'h0) begin mismatched++; $display("FAIL mid_err got %0d want 0", err_cnt); end
    if (drop_cnt !== 16'h0) begin mismatched++; $display("FAIL mid_drop got %0d want 0", drop_cnt); end
    ok_exp = 0; err_exp = 0; drop_exp = 0;
    @(negedge clk);
    reset    = 1'b0;
    da       = 8'h62;
    da_valid = 1'b1;
    b = {8'h01, 8'h99};
    send_bytes(b);
    @(negedge clk);
    da_valid  = 1'b0;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    #1;
    compared += 4;
    if (ok_cnt !== 16'h0) begin mismatched++; $display("FAIL clr_ok got %0d want 0", ok_cnt); end
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL post_rst_valid got %b want 1", out_valid); end
    if (out_sop !== 1'b1) begin mismatched++; $display("FAIL post_rst_sop got %b want 1", out_sop); end
    if (out_data !== 8'h62) begin mismatched++; $display("FAIL post_rst_data got %h want 62", out_data); end
    expq = {10'h262, 10'h001, 10'h199};
    @(negedge clk);
    out_ready = 1'b1;
    wait_rx(3);
    compared++;
    if (rx.size() !== expq.size()) begin mismatched++; $display("FAIL post_rst_len got %0d want %0d", rx.size(), expq.size()); end
    foreach (expq[i]) if (i < rx.size()) begin
      compared++;
      if (rx[i] !== expq[i]) begin mismatched++; $display("FAIL post_rst_byte%0d got %h want %h", i, rx[i], expq[i]); end
    end
    b = {8'h63, 8'h02, 8'h10, 8'h20};
    send_pkt(b);
    repeat (3) @(negedge clk);
    ok_exp = 1;
    #1;
    compared++;
    if (ok_cnt !== cexp(ok_exp)) begin mismatched++; $display("FAIL after_clr_ok got %0d want %0d", ok_cnt, cexp(ok_exp)); end
    rx = {}; expq = {};
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_truncated();
    test_bad_length();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/router_pkt_collector.md
# router_pkt_collector

Egress packet collector for one router output port. It sits directly downstream of `router_top` on a `daN`/`daN_valid` pair and checks the framing of each packet. Well-formed packets are committed into a byte FIFO; malformed or overflowing packets are discarded. Committed packets are presented to the consumer on a valid/ready byte stream with start-of-packet and end-of-packet flags.

## Interface
- `DEPTH`, 64, FIFO capacity in bytes; must be a power of two and at least `MAX_PAYLOAD`+2.
- `MAX_PAYLOAD`, 32, largest legal payload length N.
- `clk` input 1: the single clock; everything is sampled on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `da` input 8: egress byte from the router.
- `da_valid` input 1: high for every byte of a packet; must be low for at least 1 cycle between packets.
- `out_data` output 8: FIFO head byte.
- `out_sop` output 1: head byte is a packet header.
- `out_eop` output 1: head byte is the last payload byte.
- `out_valid` output 1: a committed byte is available.
- `out_ready` input 1: consumer accepts the head byte.
- `clr_stats` input 1: one-cycle pulse that clears the statistics counters.
- `ok_cnt`, `err_cnt`, `drop_cnt` output 16 each: packet statistics.

## Operation
- Packet format: header byte (`[7:4]` src port, `[3:0]` dest port), then length byte N, then N payload bytes. Total length is N+2 bytes.
- FIFO entries are 10 bits: {sop, eop, byte}. The header, length and payload bytes are all stored.
- The FIFO keeps three pointers: `rptr`, `wptr_commit` and `wptr_spec`. Writes advance `wptr_spec` only.
  - Commit: `wptr_commit` ← `wptr_spec`.
  - Rewind: `wptr_spec` ← `wptr_commit`.
- The read side sees only committed data: `out_valid` = (`rptr` != `wptr_commit`).
- Pointers are log2(`DEPTH`)+1 bits wide; the extra MSB distinguishes full from empty when the low bits are equal.
- Speculative occupancy is `wptr_spec` − `rptr`, computed modulo 2^(log2(`DEPTH`)+1).
- FSM states and transitions:
  - IDLE: `da_valid` → write the header with sop=1, go to LEN.
  - LEN: `!da_valid` → error, rewind, go to IDLE.
    - N==0 or N>`MAX_PAYLOAD` → error, rewind, go to DISCARD.
    - Otherwise write the length byte, load `remaining`=N, go to PAYLOAD.
  - PAYLOAD: `!da_valid` → error (truncated packet), rewind, go to IDLE.
    - Otherwise write the byte and decrement `remaining`.
    - The byte with `remaining`==1 is written with eop=1, then go to TAIL.
  - TAIL: `!da_valid` → commit, increment `ok_cnt`, go to IDLE.
    - `da_valid` → error (overrun), rewind, go to DISCARD.
  - DISCARD: stay until `!da_valid`, then go to IDLE.
- Full: any write attempt while speculative occupancy equals `DEPTH` drops the packet.
  - The byte is not written, `drop_cnt` increments, the FIFO rewinds and the FSM goes to DISCARD.
  - A dropped packet does not also count in `err_cnt`.
- Every framing error increments `err_cnt`.
- Pop: when `out_valid && out_ready`, `rptr` increments.
- Pop can occur on the same cycle as a write, commit or rewind. Pop never touches the write pointers, so these events are independent.
- All counters saturate at 0xFFFF.
- `clr_stats` zeroes the counters. If an increment coincides with the clear, the clear wins.

## Timing
- Reset values:
  - `out_valid`, `out_sop`, `out_eop` = 0; `out_data` = 0x00.
  - All counters = 0.
  - All pointers = 0.
  - FSM in IDLE.
- Reset asserted mid-packet discards all stored and speculative data. After reset deasserts, a `da_valid` that is already high is treated as a new header.
- Latency: the last payload byte is sampled at edge T. TAIL sees `da_valid` low at edge T+1 and commits. `out_valid` is high after edge T+1, i.e. visible in the cycle following T+1.
- The `out_*` signals are driven combinationally from the FIFO head (first-word fall-through). `out_data` is held stable while `out_valid && !out_ready`.
- Counter updates are visible 1 cycle after the event edge.

## Configuration
- `ROUTER_COLLECTOR_STATS_EN` defined: the three counters and `clr_stats` are implemented.
- Not defined: the counter logic is omitted, `ok_cnt`/`err_cnt`/`drop_cnt` are tied to 0, and `clr_stats` is ignored. The ports remain in place, and FSM and FIFO behaviour is identical in both builds.

## Structure
- `router_pkg` holds:
  - the `pkt_hdr_t` struct {src[3:0], dst[3:0]};
  - the `coll_state_e` enum {IDLE, LEN, PAYLOAD, TAIL, DISCARD};
  - the `fifo_entry_t` struct {sop, eop, data[7:0]};
  - the `STAT_W`=16 constant.
- One sub-module, `router_commit_fifo`, contains the storage and the three pointers. It exposes write, commit, rewind and pop controls plus full/empty status.
- The FSM and the counters live in `router_pkt_collector`.

## Test plan
- Single packet: hdr 0x12, N=3, payload A1 A2 A3, `out_ready`=1 → stream 12(sop) 03 A1 A2 A3(eop), `ok_cnt`=1.
- Truncated packet: hdr, N=4, 2 payload bytes, then `da_valid` low → `out_valid` stays 0, `err_cnt`=1. A following good packet is then delivered intact.
- Overrun and bad length:
  - N=2 followed by 4 valid bytes → discarded, `err_cnt`=1.
  - N=0 → discarded.
  - N=33 → discarded.
- Backpressure full: `DEPTH`=64, `out_ready`=0, send 10-byte packets (N=8) → 6 packets commit (60 bytes). The 7th is dropped with `drop_cnt`=1. After draining, the 60 bytes appear in order.
- Wrap-around: 20 back-to-back 34-byte packets with `out_ready`=1 → all delivered unchanged, `ok_cnt`=20.
- Reset mid-payload, then `clr_stats` during an increment → all outputs return to reset values and the counters read 0.
